alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised, handshaked successor to the CR16 combinational ALU. It keeps the CR16 opcode map and 5-bit status encoding and registers every result. It adds an iterative multiplier and an optional iterative divider behind a valid/ready interface. It sits between the decode/register-read stage and write-back, and may stall the pipeline while multi-cycle operations run.

## Interface
- WIDTH, 16, operand/result width; must be a power of two, minimum 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).
- I_CLK  in  1  clock; all logic on rising edge.
- I_RESET  in  1  synchronous, active-high reset.
- I_VALID  in  1  request valid.
- O_READY  out  1  block can accept a request this cycle.
- I_OPCODE  in  4  operation select.
- I_A  in  WIDTH  operand A (shift amount / subtrahend / divisor).
- I_B  in  WIDTH  operand B (shifted value / minuend / dividend).
- I_CIN  in  1  carry-in; used by ADDC only.
- O_VALID  out  1  result valid.
- I_READY  in  1  consumer accepts result.
- O_C  out  WIDTH  result.
- O_STATUS  out  5  flags: [0] C carry, [1] L unsigned low, [2] F overflow/error, [3] Z zero, [4] N negative.

## Operation
- Opcodes 0–11, in order: ADD, ADDC, MUL, SUB, NOT, AND, OR, XOR, LSH, RSH, ALSH, ARSH. Opcode 12 is DIV and 13 is MOD (both macro-gated). Opcodes 14 and 15 are reserved and return C=0, STATUS=0.
- ADD: B+A. ADDC: B+A+I_CIN. C = unsigned carry-out. F = signed overflow. N = result MSB.
- SUB: B−A. L = (B<A) unsigned. N = (B<A) signed. F = signed overflow. C = 0.
- NOT returns ~A. AND, OR and XOR are bitwise. These set only Z and N.
- Shifts use amount A[SHW-1:0] and ignore the upper bits of A.
  - LSH and ALSH shift B left and zero-fill.
  - RSH zero-fills from the left.
  - ARSH sign-fills from the left.
- MUL returns the low WIDTH bits of the product of B and A. It uses iterative shift-add with one bit per cycle. F = 1 when the signed product does not fit in WIDTH bits.
- DIV and MOD are unsigned restoring division with one bit per cycle.
  - If A==0, C = all ones for DIV and B for MOD, and F = 1.
- Z = (C==0) for every opcode. Any flag not listed for an opcode is 0.
- FSM states:
  - IDLE: no result is held. A request is accepted when I_VALID is high. MUL, DIV and MOD go to BUSY. All other opcodes go to DONE.
  - BUSY: the iteration counter counts WIDTH−1 down to 0, then the FSM goes to DONE.
  - DONE: O_VALID=1 and the result is held stable. If I_READY && I_VALID, a new request is accepted in the same cycle. If I_READY only, the FSM goes to IDLE.
- O_READY = (state==IDLE) || (state==DONE && I_READY). It is combinational and never depends on I_VALID.
- Operands and opcode are latched at acceptance. Later input changes are ignored.

## Timing
- Reset values: O_VALID=0, O_C=0, O_STATUS=0, state=IDLE, O_READY=1 from the first cycle after reset.
- Single-cycle opcodes: O_VALID rises on the edge after acceptance (latency 1). With I_READY held high, throughput is 1 per cycle.
- MUL, DIV, MOD: latency WIDTH+1 cycles from acceptance to O_VALID, and O_READY=0 throughout BUSY.
- DIV/MOD by zero: detected at acceptance, goes directly to DONE with latency 1.
- Reset asserted mid-BUSY or during DONE: the operation is aborted and the result is discarded. Outputs take their reset values on that edge.
- I_VALID while O_READY=0 is not accepted. The requester holds the request until it is accepted.

## Configuration
- ALU_DIV_EN defined: the DIV/MOD datapath is built into the iterative unit.
- ALU_DIV_EN undefined: opcodes 12 and 13 behave as reserved, and no divider logic is synthesised.

## Structure
- Package alu_pkg holds:
  - opcode localparams (ADD…MOD);
  - status index constants STATUS_INDEX_CARRY/LOW/FLAG/ZERO/NEGATIVE;
  - FSM state encoding.
- Sub-module alu_iter_muldiv holds the shared shift register, accumulator and counter for MUL/DIV/MOD. It has a start/done interface.
- Single-cycle logic and the FSM live in the top module.

## Test plan
- ADD with WIDTH=16, A=0x7FFF, B=0x0001, I_READY=1 → 1 cycle later, O_C=0x8000 and F=1, N=1, C=0, Z=0.
- SUB with A=5, B=3 → O_C=0xFFFE, L=1, N=1, Z=0. Back-to-back ADD in the next cycle → results on consecutive cycles.
- MUL with A=0x0100, B=0x0100 → O_READY low for 16 cycles, O_VALID at cycle 17, O_C=0x0000, Z=1, F=1.
- Back-pressure: hold I_READY=0 for 5 cycles after O_VALID → O_C and O_STATUS stable, and O_READY=0 until I_READY=1.
- ARSH with A=0x0014 (amount 4), B=0x8000 → O_C=0xF800. RSH with the same inputs → 0x0800.
- Reset mid-MUL at cycle 8, and (with ALU_DIV_EN) DIV by zero with B=0x1234 → reset gives O_VALID=0 next edge; DIV gives O_C=0xFFFF, F=1 with latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map, status bit positions and FSM encoding for the multicycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_LSH  = 4'd8;
    localparam logic [3:0] OP_RSH  = 4'd9;
    localparam logic [3:0] OP_ALSH = 4'd10;
    localparam logic [3:0] OP_ARSH = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;
    localparam logic [3:0] OP_MOD  = 4'd13;

    localparam int STATUS_INDEX_CARRY    = 0;
    localparam int STATUS_INDEX_LOW      = 1;
    localparam int STATUS_INDEX_FLAG     = 2;
    localparam int STATUS_INDEX_ZERO     = 3;
    localparam int STATUS_INDEX_NEGATIVE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// One-bit-per-cycle shift-add multiplier and (with ALU_DIV_EN) restoring divider
// sharing a hi/lo shift register pair and a down-counter.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    logic             active;
    logic [CW-1:0]    count;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] hi, lo, op_a, op_b;
    logic [WIDTH-1:0] hi_nxt, lo_nxt, hi_signed;
    logic [WIDTH:0]   sum;

    always_comb begin
        hi_nxt = hi;
        lo_nxt = lo;
        sum    = '0;
`ifdef ALU_DIV_EN
        if (op_r != OP_MUL) begin
            // hi < divisor always holds, so bit WIDTH of the trial is its sign
            sum = {hi, lo[WIDTH-1]} - {1'b0, op_a};
            if (!sum[WIDTH]) begin
                hi_nxt = sum[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = {hi[WIDTH-2:0], lo[WIDTH-1]};
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end
        end else
`endif
        begin
            sum    = {1'b0, hi} + (lo[0] ? {1'b0, op_b} : '0);
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            count  <= '0;
            op_r   <= OP_MUL;
            hi     <= '0;
            lo     <= '0;
            op_a   <= '0;
            op_b   <= '0;
        end else if (start) begin
            active <= 1'b1;
            count  <= CW'(WIDTH - 1);
            op_r   <= opcode;
            hi     <= '0;
            lo     <= (opcode == OP_MUL) ? a : b;
            op_a   <= a;
            op_b   <= b;
        end else if (active) begin
            hi <= hi_nxt;
            lo <= lo_nxt;
            if (count == '0) active <= 1'b0;
            else             count  <= count - 1'b1;
        end
    end

    assign done = active && (count == '0);

    // Signed high half from the unsigned product: subtract the operand cross terms.
    assign hi_signed = hi - (op_a[WIDTH-1] ? op_b : '0) - (op_b[WIDTH-1] ? op_a : '0);
    assign ovf       = (op_r == OP_MUL) && (hi_signed != {WIDTH{lo[WIDTH-1]}});
    assign result    = (op_r == OP_MOD) ? hi : lo;

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked CR16-compatible ALU with registered results and iterative MUL;
// DIV/MOD are built only when ALU_DIV_EN is defined.
//   state | meaning
//   IDLE  | no result held, ready for a request
//   BUSY  | iterative MUL/DIV/MOD in progress
//   DONE  | result valid and held until consumed
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             I_CLK,
    input  logic             I_RESET,
    input  logic             I_VALID,
    output logic             O_READY,
    input  logic [3:0]       I_OPCODE,
    input  logic [WIDTH-1:0] I_A,
    input  logic [WIDTH-1:0] I_B,
    input  logic             I_CIN,
    output logic             O_VALID,
    input  logic             I_READY,
    output logic [WIDTH-1:0] O_C,
    output logic [4:0]       O_STATUS
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] c_q, calc_c, iter_c, diff;
    logic [4:0]       status_q, calc_st, iter_st;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   amt;
    logic             from_iter, accept, iter_req, is_divop, iter_done, iter_ovf, flags_std;

`ifdef ALU_DIV_EN
    assign is_divop = (I_OPCODE == OP_DIV) || (I_OPCODE == OP_MOD);
`else
    assign is_divop = 1'b0;
`endif

    // Divide-by-zero never enters the iterative unit; it completes like a single-cycle op.
    assign iter_req = (I_OPCODE == OP_MUL) || (is_divop && (I_A != '0));
    assign O_READY  = (state == ST_IDLE) || ((state == ST_DONE) && I_READY);
    assign accept   = I_VALID && O_READY;
    assign O_VALID  = (state == ST_DONE);
    assign amt      = I_A[SHW-1:0];

    always_comb begin
        calc_c    = '0;
        calc_st   = '0;
        sum       = '0;
        diff      = '0;
        flags_std = 1'b1;
        case (I_OPCODE)
            OP_ADD, OP_ADDC: begin
                sum    = {1'b0, I_B} + {1'b0, I_A} + {{WIDTH{1'b0}}, (I_OPCODE == OP_ADDC) & I_CIN};
                calc_c = sum[WIDTH-1:0];
                calc_st[STATUS_INDEX_CARRY]    = sum[WIDTH];
                calc_st[STATUS_INDEX_FLAG]     = (I_A[WIDTH-1] == I_B[WIDTH-1]) &&
                                                 (calc_c[WIDTH-1] != I_B[WIDTH-1]);
                calc_st[STATUS_INDEX_NEGATIVE] = calc_c[WIDTH-1];
            end
            OP_SUB: begin
                diff   = I_B - I_A;
                calc_c = diff;
                calc_st[STATUS_INDEX_LOW]      = (I_B < I_A);
                calc_st[STATUS_INDEX_NEGATIVE] = ($signed(I_B) < $signed(I_A));
                calc_st[STATUS_INDEX_FLAG]     = (I_A[WIDTH-1] != I_B[WIDTH-1]) &&
                                                 (diff[WIDTH-1] != I_B[WIDTH-1]);
            end
            OP_NOT, OP_AND, OP_OR, OP_XOR: begin
                case (I_OPCODE)
                    OP_NOT:  calc_c = ~I_A;
                    OP_AND:  calc_c = I_B & I_A;
                    OP_OR:   calc_c = I_B | I_A;
                    default: calc_c = I_B ^ I_A;
                endcase
                calc_st[STATUS_INDEX_NEGATIVE] = calc_c[WIDTH-1];
            end
            OP_LSH, OP_ALSH: calc_c = I_B << amt;
            OP_RSH:          calc_c = I_B >> amt;
            OP_ARSH:         calc_c = WIDTH'($signed(I_B) >>> amt);
`ifdef ALU_DIV_EN
            OP_DIV: begin
                calc_c = '1;
                calc_st[STATUS_INDEX_FLAG] = 1'b1;
            end
            OP_MOD: begin
                calc_c = I_B;
                calc_st[STATUS_INDEX_FLAG] = 1'b1;
            end
`endif
            OP_MUL: begin
            end
            default: flags_std = 1'b0;
        endcase
        if (flags_std) calc_st[STATUS_INDEX_ZERO] = (calc_c == '0);
    end

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
        .clk    (I_CLK),
        .reset  (I_RESET),
        .start  (accept && iter_req),
        .opcode (I_OPCODE),
        .a      (I_A),
        .b      (I_B),
        .done   (iter_done),
        .result (iter_c),
        .ovf    (iter_ovf)
    );

    always_comb begin
        iter_st = '0;
        iter_st[STATUS_INDEX_FLAG] = iter_ovf;
        iter_st[STATUS_INDEX_ZERO] = (iter_c == '0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (I_VALID) state_nxt = iter_req ? ST_BUSY : ST_DONE;
            ST_BUSY: if (iter_done) state_nxt = ST_DONE;
            ST_DONE: if (I_READY) state_nxt = I_VALID ? (iter_req ? ST_BUSY : ST_DONE) : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state     <= ST_IDLE;
            c_q       <= '0;
            status_q  <= '0;
            from_iter <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                from_iter <= iter_req;
                c_q       <= calc_c;
                status_q  <= calc_st;
            end
        end
    end

    assign O_C      = from_iter ? iter_c  : c_q;
    assign O_STATUS = from_iter ? iter_st : status_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed corner cases then randomized traffic
// checked against an integer-arithmetic reference model (honours ALU_DIV_EN).
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] c;
        logic [4:0]   st;
    } exp_t;

    logic         clk, rst, i_valid, o_ready, i_cin, o_valid, i_ready;
    logic [3:0]   i_opcode;
    logic [W-1:0] i_a, i_b, o_c;
    logic [4:0]   o_status;

    int   vectors = 0;
    int   miscompares = 0;
    bit   rand_ready = 0;
    exp_t exp_q[$];

    alu_multicycle #(.WIDTH(W)) dut (
        .I_CLK(clk), .I_RESET(rst), .I_VALID(i_valid), .O_READY(o_ready),
        .I_OPCODE(i_opcode), .I_A(i_a), .I_B(i_b), .I_CIN(i_cin),
        .O_VALID(o_valid), .I_READY(i_ready), .O_C(o_c), .O_STATUS(o_status)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin);
        exp_t   r;
        int     ua, ub, sa, sb, amt, s;
        longint p;
        bit     known;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        amt = ua % W;
        r.c = '0; r.st = '0; known = 1;
        case (op)
            OP_ADD, OP_ADDC: begin
                s = ua + ub + ((op == OP_ADDC) ? int'(cin) : 0);
                r.c = s[W-1:0];
                r.st[0] = s[W];
                s = sa + sb + ((op == OP_ADDC) ? int'(cin) : 0);
                r.st[2] = (s > 32767) || (s < -32768);
                r.st[4] = r.c[W-1];
            end
            OP_MUL: begin
                p = longint'(ua) * longint'(ub);
                r.c = p[W-1:0];
                p = longint'(sa) * longint'(sb);
                r.st[2] = (p > 32767) || (p < -32768);
            end
            OP_SUB: begin
                s = ub - ua;
                r.c = s[W-1:0];
                r.st[1] = ub < ua;
                r.st[4] = sb < sa;
                s = sb - sa;
                r.st[2] = (s > 32767) || (s < -32768);
            end
            OP_NOT, OP_AND, OP_OR, OP_XOR: begin
                if (op == OP_NOT)      r.c = ~a;
                else if (op == OP_AND) r.c = a & b;
                else if (op == OP_OR)  r.c = a | b;
                else                   r.c = a ^ b;
                r.st[4] = r.c[W-1];
            end
            OP_LSH, OP_ALSH: begin s = ub << amt; r.c = s[W-1:0]; end
            OP_RSH:          begin s = ub >> amt; r.c = s[W-1:0]; end
            OP_ARSH:         begin s = sb >>> amt; r.c = s[W-1:0]; end
            OP_DIV, OP_MOD: begin
`ifdef ALU_DIV_EN
                if (ua == 0) begin
                    r.c = (op == OP_DIV) ? {W{1'b1}} : b;
                    r.st[2] = 1'b1;
                end else begin
                    s = (op == OP_DIV) ? ub / ua : ub % ua;
                    r.c = s[W-1:0];
                end
`else
                known = 0;
`endif
            end
            default: known = 0;
        endcase
        if (known) r.st[3] = (r.c == '0);
        return r;
    endfunction

    // Presents a request and holds it until accepted; returns at accept edge + #1.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, output int waited);
        i_valid = 1; i_opcode = op; i_a = a; i_b = b; i_cin = cin;
        waited = 0;
        @(negedge clk);
        while (!o_ready) begin
            waited++;
            if (waited > 200) begin
                miscompares++;
                $display("FAIL accept_timeout: op %0d not accepted after %0d cycles", op, waited);
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $fatal(1, "accept timeout");
            end
            @(negedge clk);
        end
        exp_q.push_back(model(op, a, b, cin));
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_result: got c=%h status=%b, expected no result", o_c, o_status);
                end else begin
                    e = exp_q.pop_front();
                    check("result_c", 32'(o_c), 32'(e.c));
                    check("result_status", 32'(o_status), 32'(e.st));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int   w, n, bad;
        exp_t ex;
        logic [3:0] rop;
        logic [W-1:0] ra;
        rst = 1; i_valid = 0; i_opcode = '0; i_a = '0; i_b = '0; i_cin = 0; i_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        check("reset_valid", 32'(o_valid), 0);
        check("reset_c", 32'(o_c), 0);
        check("reset_status", 32'(o_status), 0);
        check("reset_ready", 32'(o_ready), 1);

        issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, w);
        check("add_valid", 32'(o_valid), 1);
        check("add_c", 32'(o_c), 32'h8000);
        check("add_status", 32'(o_status), 32'h14);

        issue(OP_SUB, 16'h0005, 16'h0003, 1'b0, w);
        check("sub_wait", 32'(w), 0);
        check("sub_c", 32'(o_c), 32'hFFFE);
        check("sub_status", 32'(o_status), 32'h12);
        issue(OP_ADDC, 16'h1234, 16'h0101, 1'b1, w);
        check("b2b_wait", 32'(w), 0);
        check("b2b_valid", 32'(o_valid), 1);
        check("addc_c", 32'(o_c), 32'h1336);
        i_valid = 0;
        @(posedge clk); #1;
        check("idle_valid", 32'(o_valid), 0);

        issue(OP_MUL, 16'h0100, 16'h0100, 1'b0, w);
        i_valid = 0;
        n = 0;
        while (!o_valid && n < 100) begin
            check("mul_ready_low", 32'(o_ready), 0);
            @(posedge clk); #1;
            n++;
        end
        check("mul_latency", 32'(n), W);
        check("mul_c", 32'(o_c), 0);
        check("mul_status", 32'(o_status), 32'h0C);
        @(posedge clk); #1;

        i_ready = 0;
        ex = model(OP_XOR, 16'hA5A5, 16'h0F0F, 1'b0);
        issue(OP_XOR, 16'hA5A5, 16'h0F0F, 1'b0, w);
        i_valid = 0;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(o_valid), 1);
            check("bp_c", 32'(o_c), 32'(ex.c));
            check("bp_status", 32'(o_status), 32'(ex.st));
            check("bp_ready", 32'(o_ready), 0);
        end
        i_ready = 1;
        #1;
        check("bp_ready_release", 32'(o_ready), 1);
        @(posedge clk); #1;

        issue(OP_ARSH, 16'h0014, 16'h8000, 1'b0, w);
        check("arsh_c", 32'(o_c), 32'hF800);
        check("arsh_status", 32'(o_status), 0);
        issue(OP_RSH, 16'h0014, 16'h8000, 1'b0, w);
        check("rsh_c", 32'(o_c), 32'h0800);
        i_valid = 0;
        @(posedge clk); #1;

        issue(OP_MUL, 16'h1234, 16'h5678, 1'b0, w);
        i_valid = 0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1;
        exp_q.delete();
        @(posedge clk); #1;
        check("rst_mid_valid", 32'(o_valid), 0);
        check("rst_mid_c", 32'(o_c), 0);
        check("rst_mid_status", 32'(o_status), 0);
        rst = 0;
        check("rst_mid_ready", 32'(o_ready), 1);
        bad = 0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (o_valid) bad++;
        end
        check("abort_no_result", 32'(bad), 0);

        issue(OP_DIV, 16'h0000, 16'h1234, 1'b0, w);
        i_valid = 0;
        check("div0_valid", 32'(o_valid), 1);
`ifdef ALU_DIV_EN
        check("div0_c", 32'(o_c), 32'hFFFF);
        check("div0_status", 32'(o_status), 32'h04);
`else
        check("div_reserved_c", 32'(o_c), 0);
        check("div_reserved_status", 32'(o_status), 0);
`endif
        @(posedge clk); #1;

        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            issue(rop, ra, W'($urandom), 1'($urandom), w);
            if ($urandom_range(0, 2) == 0) begin
                i_valid = 0;
                @(posedge clk); #1;
            end
        end
        i_valid = 0;
        rand_ready = 0;
        i_ready = 1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
